// File: rtl/merge_stage.sv
// merge_stage: two-input round-robin join; each input has a 2-entry skid FIFO.
// Define MERGE_STATS_EN to add the per-input delivered-word counters cnt1_o/cnt2_o.

module merge_fifo #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             v,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             nempty
);
   logic [WIDTH-1:0] mem [2];
   logic             wptr, rptr, wr;
   logic [1:0]       count;

   // stall is a decode of the registered count only
   assign full   = (count == 2'd2);
   assign nempty = (count != 2'd0);
   assign head   = mem[rptr];
   assign wr     = v & ~full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wptr   <= 1'b0;
         rptr   <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (wr) begin
            mem[wptr] <= din;
            wptr      <= ~wptr;
         end
         if (pop) rptr <= ~rptr;
         count <= count + {1'b0, wr} - {1'b0, pop};
      end
   end
endmodule

module merge_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             v_i1,
   input  logic [WIDTH-1:0] data_i1,
   output logic             stall_o1,
   input  logic             v_i2,
   input  logic [WIDTH-1:0] data_i2,
   output logic             stall_o2,
   output logic             v_o,
   output logic [WIDTH-1:0] data_o,
   output logic             src_o,
   input  logic             stall_i
`ifdef MERGE_STATS_EN
  ,output logic [15:0]      cnt1_o,
   output logic [15:0]      cnt2_o
`endif
);
   logic [1:0]            vin, full, nempty, pop;
   logic [1:0][WIDTH-1:0] din, head;
   logic                  ld, gnt, sel, last_grant;

   assign vin      = {v_i2, v_i1};
   assign din      = {data_i2, data_i1};
   assign stall_o1 = full[0];
   assign stall_o2 = full[1];

   for (genvar k = 0; k < 2; k++) begin : g_fifo
      merge_fifo #(.WIDTH(WIDTH)) u_fifo (
         .clk    (clk),
         .reset  (reset),
         .v      (vin[k]),
         .din    (din[k]),
         .pop    (pop[k]),
         .head   (head[k]),
         .full   (full[k]),
         .nempty (nempty[k])
      );
   end

   // a bubble in the output register is refilled even under stall_i
   assign ld = ~v_o | ~stall_i;

   always_comb begin
      gnt = 1'b0;
      sel = 1'b0;
      if (nempty[0] && nempty[1]) begin
         gnt = 1'b1;
         sel = ~last_grant;
      end else if (nempty[0]) begin
         gnt = 1'b1;
      end else if (nempty[1]) begin
         gnt = 1'b1;
         sel = 1'b1;
      end
   end

   assign pop = {ld & gnt & sel, ld & gnt & ~sel};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_o        <= 1'b0;
         data_o     <= '0;
         src_o      <= 1'b0;
         last_grant <= 1'b1;
      end else if (ld) begin
         v_o <= gnt;
         if (gnt) begin
            data_o     <= head[sel];
            src_o      <= sel;
            last_grant <= sel;
         end
      end
   end

`ifdef MERGE_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt1_o <= 16'd0;
         cnt2_o <= 16'd0;
      end else begin
         if (pop[0]) cnt1_o <= cnt1_o + 16'd1;
         if (pop[1]) cnt2_o <= cnt2_o + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_merge_stage.sv
// Bench for merge_stage: queue-based reference model of the two skid FIFOs and round-robin output.
module tb_merge_stage;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         v_i1, v_i2, stall_i;
   logic [W-1:0] data_i1, data_i2;
   logic         stall_o1, stall_o2, v_o, src_o;
   logic [W-1:0] data_o;
`ifdef MERGE_STATS_EN
   logic [15:0]  cnt1_o, cnt2_o;
`endif

   merge_stage #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .v_i1(v_i1), .data_i1(data_i1), .stall_o1(stall_o1),
      .v_i2(v_i2), .data_i2(data_i2), .stall_o2(stall_o2),
      .v_o(v_o), .data_o(data_o), .src_o(src_o), .stall_i(stall_i)
`ifdef MERGE_STATS_EN
     ,.cnt1_o(cnt1_o), .cnt2_o(cnt2_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [W-1:0] q1[$], q2[$];
   logic         m_v, m_src, m_last;
   logic [W-1:0] m_d;
   logic [15:0]  m_c1, m_c2;
   bit           acc1, acc2;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("v_o", W'(v_o), W'(m_v));
      chk("data_o", data_o, m_d);
      chk("src_o", W'(src_o), W'(m_src));
      chk("stall_o1", W'(stall_o1), W'(q1.size() == 2));
      chk("stall_o2", W'(stall_o2), W'(q2.size() == 2));
`ifdef MERGE_STATS_EN
      chk("cnt1_o", W'(cnt1_o), W'(m_c1));
      chk("cnt2_o", W'(cnt2_o), W'(m_c2));
`endif
   endtask

   task automatic model_reset();
      q1.delete(); q2.delete();
      m_v = 0; m_d = '0; m_src = 0; m_last = 1; m_c1 = 0; m_c2 = 0;
   endtask

   // one clock: inputs already applied; advance model, then check at negedge
   task automatic step();
      int pick;
      acc1 = v_i1 && q1.size() < 2;
      acc2 = v_i2 && q2.size() < 2;
      if (!m_v || !stall_i) begin
         pick = -1;
         if (q1.size() > 0 && q2.size() > 0) pick = (m_last == 1'b1) ? 0 : 1;
         else if (q1.size() > 0)             pick = 0;
         else if (q2.size() > 0)             pick = 1;
         if (pick == 0) begin
            m_d = q1.pop_front(); m_v = 1; m_src = 0; m_last = 0; m_c1++;
         end else if (pick == 1) begin
            m_d = q2.pop_front(); m_v = 1; m_src = 1; m_last = 1; m_c2++;
         end else m_v = 0;
      end
      if (acc1) q1.push_back(data_i1);
      if (acc2) q2.push_back(data_i2);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input logic a, input logic [W-1:0] da, input logic b,
                        input logic [W-1:0] db, input logic st);
      v_i1 = a; data_i1 = da; v_i2 = b; data_i2 = db; stall_i = st;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, $urandom, 0, $urandom, 0);
   endtask

   initial begin
      logic [W-1:0] n1, n2, bw;
      // reset held with random inputs
      reset = 0; model_reset();
      for (int i = 0; i < 5; i++) begin
         v_i1 = 1'($urandom); v_i2 = 1'($urandom); stall_i = 1'($urandom);
         data_i1 = $urandom; data_i2 = $urandom;
         @(posedge clk); @(negedge clk);
         check_all();
      end
      reset = 1;

      // contention: first tie goes to input 1, then alternate
      n1 = 32'hA0; n2 = 32'hB0;
      for (int i = 0; i < 10; i++) begin
         drive(1, n1, 1, n2, 0);
         if (acc1) n1++;
         if (acc2) n2++;
         if (i == 1) begin
            chk("first_tie_data", data_o, 32'hA0);
            chk("first_tie_src", W'(src_o), '0);
         end
         if (i == 2) chk("second_word", data_o, 32'hB0);
      end
      idle(5);

      // single stream on input 1
      drive(1, 32'h1, 0, 0, 0);
      drive(1, 32'h2, 0, 0, 0);
      chk("single_c2_v", W'(v_o), W'(1));
      chk("single_c2_d", data_o, 32'h1);
      drive(1, 32'h3, 0, 0, 0);
      idle(4);

      // backpressure: fill both FIFOs, then drain
      n1 = 32'hC0; n2 = 32'hD0;
      for (int i = 0; i < 6; i++) begin
         drive(1, n1, 1, n2, 1);
         if (acc1) n1++;
         if (acc2) n2++;
      end
      chk("bp_stall1", W'(stall_o1), W'(1));
      chk("bp_stall2", W'(stall_o2), W'(1));
      idle(7);

      // bubble collapse under stall
      bw = $urandom;
      drive(0, 0, 1, bw, 1);
      drive(0, 0, 0, 0, 1);
      chk("bubble_v", W'(v_o), W'(1));
      chk("bubble_d", data_o, bw);
      idle(3);

      // random traffic
      for (int i = 0; i < 400; i++)
         drive(1'($urandom), $urandom, 1'($urandom), $urandom, ($urandom_range(0, 3) == 0));

      // asynchronous reset mid-stream
      for (int i = 0; i < 6; i++) drive(1, $urandom, 1, $urandom, 1);
      #2 reset = 0;
      #1 model_reset();
      check_all();
      @(posedge clk); @(negedge clk);
      reset = 1;
      idle(2);

`ifdef MERGE_STATS_EN
      // counter wrap: 65536 words through input 1
      for (int i = 0; i < 65536; i++) drive(1, W'(i), 0, 0, 0);
      idle(4);
      chk("cnt1_wrap", W'(cnt1_o), '0);
      chk("cnt2_zero", W'(cnt2_o), '0);
      for (int i = 0; i < 4; i++) drive(1, $urandom, 1, $urandom, 0);
      #2 reset = 0;
      #1 model_reset();
      check_all();
      @(posedge clk); @(negedge clk);
      reset = 1;
      idle(2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
